if_prefetch_stage: RTL and testbench

//  Parametrised instruction-fetch stage that replaces the hard-wired ROM fetch with a handshaked

---
 rtl/if_prefetch_stage.sv | 121 ++++++++++++
 tb/tb_if_prefetch_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: handshaked imem port, credit-limited request issue,
// in-order prefetch FIFO of {pc, instr}, and branch redirect with discard of stale responses.
module if_prefetch_stage #(
  parameter int unsigned           XLEN     = 32,
  parameter int unsigned           DEPTH    = 4,
  parameter logic [XLEN-1:0]       RESET_PC = '0,
  parameter int unsigned           PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_address,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
  localparam logic [CW:0]     CREDIT_LIMIT = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outst;
  logic [CW-1:0]   discard;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [XLEN-1:0] fifo_pc   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];

  logic [CW:0]     credit_used;
  logic            credit_ok;
  logic            req_fire;
  logic            rsp_ok;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirect_pc;

  // Handshake and bookkeeping strobes
  always_comb begin
    credit_used    = (CW + 1)'(count) + (CW + 1)'(outst);
    credit_ok      = credit_used < CREDIT_LIMIT;
    imem_req_valid = !rst && !branch_taken && credit_ok;
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored entirely.
    rsp_ok         = imem_rsp_valid && (outst != '0);
    rsp_drop       = rsp_ok && (discard != '0);
    push           = rsp_ok && !rsp_drop && !branch_taken;
    if_valid       = (count != '0) && !branch_taken && !rst;
    pop            = if_valid && id_ready;
    redirect_pc    = branch_address & ~XLEN'(3);
  end

  // FIFO head presented to ID; NOP when nothing valid
  always_comb begin
    if_instr = '0;
    if_pc    = '0;
    if (if_valid) begin
      if_instr = fifo_data[rd_ptr];
      if_pc    = fifo_pc[rd_ptr];
    end
  end

  // Control state: PCs, occupancy, in-flight and stale-response counters
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      count    <= '0;
      outst    <= '0;
      discard  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (branch_taken) begin
      // Every request still in flight after this cycle belongs to the old path,
      // so discard tracks outst exactly; repeated redirects keep all of them marked.
      fetch_pc <= redirect_pc;
      rsp_pc   <= redirect_pc;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      outst    <= outst - CW'(rsp_ok);
      discard  <= outst - CW'(rsp_ok);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + STEP;
      end
      outst <= outst + CW'(req_fire) - CW'(rsp_ok);
      if (rsp_drop) begin
        discard <= discard - CW'(1);
      end
      if (push) begin
        rsp_pc <= rsp_pc + STEP;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; contents are only meaningful under count
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_pc[wr_ptr]   <= rsp_pc;
      fifo_data[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: memory model with configurable latency, a scoreboard of
// expected {pc, instr} pushed at each accepted request, and directed corner sequences.
module tb_if_prefetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  always #5 clk = ~clk;

  if_prefetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  typedef struct { logic [31:0] addr; int due; } mem_ent_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_ent_t;
  typedef struct { int lat; int first_valid; int valid_cnt; } vec_t;

  mem_ent_t    mem_q[$];
  exp_ent_t    exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          lat      = 1;
  logic [31:0] exp_req_pc = 32'd0;
  int          n_pop    = 0;
  int          n_fire   = 0;
  logic [31:0] first_pop_pc = 32'd0;
  logic [31:0] last_addr;
  logic        last_req_valid;
  logic        last_if_valid;

  // Compare and log one value
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, settle, check, update models, advance to next negedge
  task automatic step(input logic r, input logic br, input logic [31:0] ba,
                      input logic idr, input logic rr);
    logic     rv;
    exp_ent_t e;
    rst            = r;
    branch_taken   = br;
    branch_address = ba;
    id_ready       = idr;
    imem_req_ready = rr;
    rv = 1'b0;
    if (!r && mem_q.size() > 0) begin
      if (mem_q[0].due <= cyc) rv = 1'b1;
    end
    imem_rsp_valid = rv;
    imem_rsp_data  = 32'd0;
    if (rv) imem_rsp_data = mem_q[0].addr >> 2;
    #1;
    last_addr      = imem_req_addr;
    last_req_valid = imem_req_valid;
    last_if_valid  = if_valid;
    if (r || br) begin
      check("req_valid_blocked", 32'(imem_req_valid), 32'd0);
      check("if_valid_blocked", 32'(if_valid), 32'd0);
    end
    if (!if_valid) begin
      check("nop_when_idle", if_instr, 32'd0);
    end else if (id_ready) begin
      n_pop++;
      if (n_pop == 1) first_pop_pc = if_pc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc 0x%08h, none expected (cycle %0d)", if_pc, cyc);
      end else begin
        e = exp_q.pop_front();
        check("if_pc", if_pc, e.pc);
        check("if_instr", if_instr, e.instr);
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      n_fire++;
      check("req_addr", imem_req_addr, exp_req_pc);
      exp_q.push_back('{exp_req_pc, exp_req_pc >> 2});
      mem_q.push_back('{imem_req_addr, cyc + lat});
      exp_req_pc += 32'd4;
    end
    if (rv) void'(mem_q.pop_front());
    if (r) begin
      mem_q.delete();
      exp_q.delete();
      exp_req_pc = 32'd0;
    end else if (br) begin
      exp_q.delete();
      exp_req_pc = ba & ~32'd3;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    cyc    = 0;
    n_pop  = 0;
    n_fire = 0;
  endtask

  // Stop issuing and let everything in flight come back; all expected words must appear
  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && mem_q.size() == 0) break;
      step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    end
    check("drained", 32'(exp_q.size()), 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  initial begin
    vec_t        vecs[3];
    int          fv;
    int          vcnt;
    logic [31:0] held;

    rst = 1'b1; branch_taken = 1'b0; branch_address = 32'd0; id_ready = 1'b1;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    @(negedge clk);

    // Latency table: first if_valid at cycle lat+1; full throughput checked where it holds
    vecs[0] = '{1, 2, 10};
    vecs[1] = '{2, 3, 9};
    vecs[2] = '{3, 4, -1};
    for (int v = 0; v < 3; v++) begin
      lat = vecs[v].lat;
      do_reset();
      fv = -1;
      vcnt = 0;
      for (int k = 0; k < 12; k++) begin
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        if (last_if_valid) begin
          if (fv < 0) fv = k;
          vcnt++;
        end
      end
      check("first_valid_cycle", 32'(fv), 32'(vecs[v].first_valid));
      if (vecs[v].valid_cnt >= 0) check("valid_cycles", 32'(vcnt), 32'(vecs[v].valid_cnt));
      check("first_pc_after_reset", first_pop_pc, 32'd0);
      drain();
    end

    // ID stall: credit limit caps requests at DEPTH, then buffered words drain in order
    lat = 1;
    do_reset();
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    check("stall_fires", 32'(n_fire), 32'd4);
    check("stall_req_valid", 32'(last_req_valid), 32'd0);
    n_pop = 0;
    drain();
    check("stall_drain_count", 32'(n_pop), 32'd4);

    // Redirect with 3 requests in flight on a 3-cycle memory
    lat = 3;
    do_reset();
    run(3);
    step(1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
    n_pop = 0;
    run(12);
    check("redirect_first_pc", first_pop_pc, 32'h100);
    drain();

    // Memory not ready: address held, resumes at held address
    lat = 1;
    do_reset();
    run(3);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    held = last_addr;
    check("held_addr", held, 32'h0c);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      check("held_addr_stable", last_addr, held);
      check("held_req_valid", 32'(last_req_valid), 32'd1);
    end
    run(6);
    drain();

    // Misaligned target, redirect coinciding with a response
    lat = 1;
    do_reset();
    run(5);
    step(1'b0, 1'b1, 32'h103, 1'b1, 1'b1);
    n_pop = 0;
    run(6);
    check("aligned_redirect_pc", first_pop_pc, 32'h100);
    drain();

    // Back-to-back redirects with responses still in flight
    lat = 3;
    do_reset();
    run(3);
    step(1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h300, 1'b1, 1'b1);
    n_pop = 0;
    run(14);
    check("b2b_redirect_pc", first_pop_pc, 32'h300);
    drain();

    // Reset mid-stream with requests outstanding
    lat = 3;
    do_reset();
    run(5);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    n_pop = 0;
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    check("post_rst_if_valid", 32'(last_if_valid), 32'd0);
    check("post_rst_req_valid", 32'(last_req_valid), 32'd1);
    check("post_rst_req_addr", last_addr, 32'd0);
    run(8);
    check("post_rst_first_pc", first_pop_pc, 32'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
